// File: rtl/lpc_host_if.sv
// Request/response handshake and LAD/LFRAME# bus bundle for lpc_host.
// The master modport is the host's view; the slave modport is the requester/target view.
interface lpc_host_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic        req_mem;
    logic [31:0] req_addr;
    logic [7:0]  req_wdata;
    logic        rsp_valid;
    logic [7:0]  rsp_rdata;
    logic [1:0]  rsp_status;
    logic        lframe_n;
    logic [3:0]  lad_out;
    logic        lad_oe;
    logic [3:0]  lad_in;

    modport master (
        input  req_valid, req_write, req_mem, req_addr, req_wdata, lad_in,
        output req_ready, rsp_valid, rsp_rdata, rsp_status, lframe_n, lad_out, lad_oe
    );

    modport slave (
        output req_valid, req_write, req_mem, req_addr, req_wdata, lad_in,
        input  req_ready, rsp_valid, rsp_rdata, rsp_status, lframe_n, lad_out, lad_oe
    );
endinterface

// File: rtl/lpc_host.sv
// LPC host: runs one single-byte I/O cycle per accepted request.
// Define LPC_HOST_MEM_EN to add memory cycles; otherwise they complete at once with status 11.
module lpc_host #(
    parameter int unsigned SYNC_TIMEOUT = 8,
    parameter int unsigned LWAIT_MAX    = 255
) (
    input  logic       lpc_clock,
    input  logic       lpc_reset,
    lpc_host_if.master bus
);
`ifdef LPC_HOST_MEM_EN
    localparam int unsigned AW = 32;
    localparam logic MemEn = 1'b1;
    logic [AW-1:0] w_addr_load;
    // I/O addresses are left-aligned so the outgoing nibble is always the top one.
    assign w_addr_load = bus.req_mem ? bus.req_addr : {bus.req_addr[15:0], 16'h0000};
`else
    localparam int unsigned AW = 16;
    localparam logic MemEn = 1'b0;
    logic [AW-1:0] w_addr_load;
    logic          w_unused_addr;
    assign w_addr_load   = bus.req_addr[15:0];
    assign w_unused_addr = ^bus.req_addr[31:16];
`endif

    typedef enum logic [3:0] {
        StIdle, StStart, StCyctype, StAddr, StWdata, StTarH,
        StSync, StRdata, StTarP, StAbort, StDone
    } state_e;

    state_e        r_state, w_state;
    logic [2:0]    r_cnt, w_cnt;
    logic [15:0]   r_swait, w_swait;
    logic [15:0]   r_lwait, w_lwait;
    logic [AW-1:0] r_addr, w_addr;
    logic [7:0]    r_rbuf, w_rbuf;
    logic [7:0]    r_rdata, w_rdata;
    logic [1:0]    r_status, w_status;
    logic [1:0]    r_sync_st, w_sync_st;
    logic          r_write, r_mem;
    logic [7:0]    r_wdata;

    logic          w_accept, w_ready, w_rsp_valid, w_lframe_n, w_lad_oe;
    logic [3:0]    w_lad_out;
    logic [2:0]    w_addr_last;

    assign w_accept    = (r_state == StIdle) && bus.req_valid;
    assign w_addr_last = r_mem ? 3'd7 : 3'd3;

    always_ff @(posedge lpc_clock or negedge lpc_reset) begin
        if (!lpc_reset) begin
            r_state   <= StIdle;
            r_cnt     <= '0;
            r_swait   <= '0;
            r_lwait   <= '0;
            r_addr    <= '0;
            r_rbuf    <= '0;
            r_rdata   <= '0;
            r_status  <= '0;
            r_sync_st <= '0;
            r_write   <= 1'b0;
            r_mem     <= 1'b0;
            r_wdata   <= '0;
        end else begin
            r_state   <= w_state;
            r_cnt     <= w_cnt;
            r_swait   <= w_swait;
            r_lwait   <= w_lwait;
            r_addr    <= w_addr;
            r_rbuf    <= w_rbuf;
            r_rdata   <= w_rdata;
            r_status  <= w_status;
            r_sync_st <= w_sync_st;
            if (w_accept) begin
                r_write <= bus.req_write;
                r_mem   <= bus.req_mem;
                r_wdata <= bus.req_wdata;
            end
        end
    end

    always_comb begin
        w_state     = r_state;
        w_cnt       = r_cnt;
        w_swait     = r_swait;
        w_lwait     = r_lwait;
        w_addr      = r_addr;
        w_rbuf      = r_rbuf;
        w_rdata     = r_rdata;
        w_status    = r_status;
        w_sync_st   = r_sync_st;
        w_ready     = 1'b0;
        w_rsp_valid = 1'b0;
        w_lframe_n  = 1'b1;
        w_lad_out   = 4'hF;
        w_lad_oe    = 1'b0;
        case (r_state)
            StIdle: begin
                w_ready = 1'b1;
                if (w_accept) begin
                    w_cnt  = '0;
                    w_addr = w_addr_load;
                    if (bus.req_mem && !MemEn) begin
                        w_state  = StDone;
                        w_status = 2'b11;
                    end else begin
                        w_state = StStart;
                    end
                end
            end
            StStart: begin
                w_lframe_n = 1'b0;
                w_lad_out  = 4'h0;
                w_lad_oe   = 1'b1;
                w_state    = StCyctype;
            end
            StCyctype: begin
                w_lad_out = {1'b0, r_mem, r_write, 1'b0};
                w_lad_oe  = 1'b1;
                w_cnt     = '0;
                w_state   = StAddr;
            end
            StAddr: begin
                w_lad_out = r_addr[AW-1 -: 4];
                w_lad_oe  = 1'b1;
                w_addr    = {r_addr[AW-5:0], 4'h0};
                if (r_cnt == w_addr_last) begin
                    w_cnt   = '0;
                    w_state = r_write ? StWdata : StTarH;
                end else begin
                    w_cnt = r_cnt + 3'd1;
                end
            end
            StWdata: begin
                w_lad_out = r_cnt[0] ? r_wdata[7:4] : r_wdata[3:0];
                w_lad_oe  = 1'b1;
                w_cnt     = r_cnt[0] ? 3'd0 : 3'd1;
                if (r_cnt[0]) w_state = StTarH;
            end
            StTarH: begin
                w_lad_oe = !r_cnt[0];
                w_cnt    = r_cnt[0] ? 3'd0 : 3'd1;
                if (r_cnt[0]) begin
                    w_swait = '0;
                    w_lwait = '0;
                    w_state = StSync;
                end
            end
            StSync: begin
                case (bus.lad_in)
                    4'b0000, 4'b1010: begin
                        w_sync_st = (bus.lad_in == 4'b1010) ? 2'b01 : 2'b00;
                        w_cnt     = '0;
                        w_state   = r_write ? StTarP : StRdata;
                    end
                    4'b0110: begin
                        w_swait = '0;
                        if (r_lwait == 16'(LWAIT_MAX - 1)) begin
                            w_cnt   = '0;
                            w_state = StAbort;
                        end else begin
                            w_lwait = r_lwait + 16'd1;
                        end
                    end
                    default: begin
                        if (r_swait == 16'(SYNC_TIMEOUT - 1)) begin
                            w_cnt   = '0;
                            w_state = StAbort;
                        end else begin
                            w_swait = r_swait + 16'd1;
                        end
                    end
                endcase
            end
            StRdata: begin
                if (r_cnt[0]) w_rbuf[7:4] = bus.lad_in;
                else          w_rbuf[3:0] = bus.lad_in;
                w_cnt = r_cnt[0] ? 3'd0 : 3'd1;
                if (r_cnt[0]) w_state = StTarP;
            end
            StTarP: begin
                w_cnt = r_cnt[0] ? 3'd0 : 3'd1;
                if (r_cnt[0]) begin
                    w_status = r_sync_st;
                    if (!r_write) w_rdata = r_rbuf;
                    w_state = StDone;
                end
            end
            StAbort: begin
                // Four clocks of LFRAME# low with 1111, then one released clock.
                if (r_cnt != 3'd4) begin
                    w_lframe_n = 1'b0;
                    w_lad_oe   = 1'b1;
                    w_cnt      = r_cnt + 3'd1;
                end else begin
                    w_cnt    = '0;
                    w_status = 2'b10;
                    w_state  = StDone;
                end
            end
            StDone: begin
                w_rsp_valid = 1'b1;
                w_state     = StIdle;
            end
            default: w_state = StIdle;
        endcase
    end

    assign bus.req_ready  = w_ready;
    assign bus.rsp_valid  = w_rsp_valid;
    assign bus.rsp_rdata  = r_rdata;
    assign bus.rsp_status = r_status;
    assign bus.lframe_n   = w_lframe_n;
    assign bus.lad_out    = w_lad_out;
    assign bus.lad_oe     = w_lad_oe;
endmodule

// File: tb/tb_lpc_host.sv
// Directed bench for lpc_host: a scoreboard queue holds expected responses per request,
// and LAD/LFRAME# traces are captured per cycle (cycle 0 = first clock after acceptance).
`timescale 1ns/1ps
module tb_lpc_host;
    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    lpc_host_if bus();

    lpc_host #(
        .SYNC_TIMEOUT(8),
        .LWAIT_MAX   (255)
    ) u_dut (
        .lpc_clock(clk),
        .lpc_reset(rst_n),
        .bus      (bus.master)
    );

    typedef struct {
        string      tag;
        logic [7:0] rdata;
        logic [1:0] status;
        int         cyc;
    } exp_t;

    exp_t       sb[$];
    int         n_assert = 0;
    int         n_fail   = 0;
    logic [3:0] lad_seq [64];
    logic [3:0] mon_lad [64];
    logic       mon_oe  [64];
    logic       mon_fr  [64];
    logic       mon_rdy [64];
    logic [3:0] exp_wr  [9];
    logic [3:0] exp_mem [9];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic clr_lad();
        for (int i = 0; i < 64; i++) lad_seq[i] = 4'hF;
    endtask

    task automatic run_txn(input string tag, input logic wr, input logic mem,
                           input logic [31:0] addr, input logic [7:0] wd, input logic hold,
                           input logic [7:0] e_rdata, input logic [1:0] e_status, input int e_cyc);
        exp_t e;
        exp_t g;
        int   k;
        bit   got;
        e.tag = tag; e.rdata = e_rdata; e.status = e_status; e.cyc = e_cyc;
        sb.push_back(e);
        bus.lad_in = 4'hF;
        @(negedge clk);
        k = 0;
        while (!bus.req_ready && k < 50) begin
            @(negedge clk);
            k++;
        end
        bus.req_valid = 1'b1;
        bus.req_write = wr;
        bus.req_mem   = mem;
        bus.req_addr  = addr;
        bus.req_wdata = wd;
        @(negedge clk);
        if (!hold) bus.req_valid = 1'b0;
        k   = 0;
        got = 0;
        while (!got && k < 64) begin
            bus.lad_in = lad_seq[k];
            mon_lad[k] = bus.lad_out;
            mon_oe[k]  = bus.lad_oe;
            mon_fr[k]  = bus.lframe_n;
            mon_rdy[k] = bus.req_ready;
            if (bus.rsp_valid) begin
                got           = 1;
                bus.req_valid = 1'b0;
                g = sb.pop_front();
                chk({g.tag, "/status"}, 32'(bus.rsp_status), 32'(g.status));
                chk({g.tag, "/rdata"}, 32'(bus.rsp_rdata), 32'(g.rdata));
                chk({g.tag, "/latency"}, 32'(k), 32'(g.cyc));
            end else begin
                @(negedge clk);
                k++;
            end
        end
        chk({tag, "/rsp_seen"}, 32'(got), 1);
        if (!got) begin
            bus.req_valid = 1'b0;
            sb.delete(0);
        end
        bus.lad_in = 4'hF;
    endtask

    initial begin
        exp_wr  = '{4'h0, 4'h2, 4'h0, 4'h0, 4'h8, 4'h0, 4'h5, 4'hA, 4'hF};
        exp_mem = '{4'h4, 4'hF, 4'hF, 4'hF, 4'hF, 4'hF, 4'hF, 4'hF, 4'h0};
        bus.req_valid = 1'b0;
        bus.req_write = 1'b0;
        bus.req_mem   = 1'b0;
        bus.req_addr  = '0;
        bus.req_wdata = '0;
        bus.lad_in    = 4'hF;
        clr_lad();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("reset/ready", 32'(bus.req_ready), 1);
        chk("reset/lframe_n", 32'(bus.lframe_n), 1);
        chk("reset/lad_out", 32'(bus.lad_out), 'hF);
        chk("reset/lad_oe", 32'(bus.lad_oe), 0);
        chk("reset/rsp_valid", 32'(bus.rsp_valid), 0);
        chk("reset/status", 32'(bus.rsp_status), 0);
        chk("reset/rdata", 32'(bus.rsp_rdata), 0);

        // I/O write 0x0080 <- 0xA5, ready SYNC at once.
        clr_lad();
        lad_seq[10] = 4'h0;
        run_txn("io_wr", 1'b1, 1'b0, 32'h0000_0080, 8'hA5, 1'b0, 8'h00, 2'b00, 13);
        chk("io_wr/start_lframe", 32'(mon_fr[0]), 0);
        chk("io_wr/cyc_lframe", 32'(mon_fr[1]), 1);
        for (int i = 0; i < 9; i++) begin
            chk($sformatf("io_wr/lad%0d", i), 32'(mon_lad[i]), 32'(exp_wr[i]));
            chk($sformatf("io_wr/oe%0d", i), 32'(mon_oe[i]), 1);
        end
        chk("io_wr/tar2_oe", 32'(mon_oe[9]), 0);
        chk("io_wr/sync_oe", 32'(mon_oe[10]), 0);

        // I/O read 0x03F8 with two long waits; req_valid held high throughout.
        clr_lad();
        lad_seq[8] = 4'h6; lad_seq[9] = 4'h6; lad_seq[10] = 4'h0;
        lad_seq[11] = 4'h3; lad_seq[12] = 4'hC;
        run_txn("io_rd", 1'b0, 1'b0, 32'h0000_03F8, 8'h00, 1'b1, 8'hC3, 2'b00, 15);
        chk("io_rd/cyctype", 32'(mon_lad[1]), 'h0);
        chk("io_rd/a0", 32'(mon_lad[2]), 'h0);
        chk("io_rd/a1", 32'(mon_lad[3]), 'h3);
        chk("io_rd/a2", 32'(mon_lad[4]), 'hF);
        chk("io_rd/a3", 32'(mon_lad[5]), 'h8);
        chk("io_rd/tar1_oe", 32'(mon_oe[6]), 1);
        chk("io_rd/tar2_oe", 32'(mon_oe[7]), 0);
        chk("io_rd/busy_ready", 32'(mon_rdy[3]), 0);

        // I/O write: one short wait (0101) then SYNC error (1010); rdata must hold.
        clr_lad();
        lad_seq[10] = 4'h5; lad_seq[11] = 4'hA;
        run_txn("io_wr_err", 1'b1, 1'b0, 32'h0000_002E, 8'h00, 1'b0, 8'hC3, 2'b01, 14);

        // I/O read with no target: 8 SYNC clocks, then abort sequence.
        clr_lad();
        run_txn("io_timeout", 1'b0, 1'b0, 32'h0000_0060, 8'h00, 1'b0, 8'hC3, 2'b10, 21);
        chk("io_timeout/last_sync_lframe", 32'(mon_fr[15]), 1);
        for (int i = 16; i < 20; i++) begin
            chk($sformatf("io_timeout/abort_lframe%0d", i), 32'(mon_fr[i]), 0);
            chk($sformatf("io_timeout/abort_lad%0d", i), 32'(mon_lad[i]), 'hF);
            chk($sformatf("io_timeout/abort_oe%0d", i), 32'(mon_oe[i]), 1);
        end
        chk("io_timeout/release_lframe", 32'(mon_fr[20]), 1);
        chk("io_timeout/release_oe", 32'(mon_oe[20]), 0);

`ifdef LPC_HOST_MEM_EN
        clr_lad();
        lad_seq[12] = 4'hA; lad_seq[13] = 4'h2; lad_seq[14] = 4'h1;
        run_txn("mem_rd", 1'b0, 1'b1, 32'hFFFF_FFF0, 8'h00, 1'b0, 8'h12, 2'b01, 17);
        for (int i = 0; i < 9; i++)
            chk($sformatf("mem_rd/lad%0d", i + 1), 32'(mon_lad[i + 1]), 32'(exp_mem[i]));
`else
        clr_lad();
        run_txn("mem_wr_unsup", 1'b1, 1'b1, 32'h0000_1234, 8'h55, 1'b0, 8'hC3, 2'b11, 0);
        chk("mem_wr_unsup/lframe", 32'(mon_fr[0]), 1);
        chk("mem_wr_unsup/oe", 32'(mon_oe[0]), 0);
`endif

        // Reset asserted during the ADDR phase of an I/O write.
        clr_lad();
        @(negedge clk);
        bus.req_valid = 1'b1;
        bus.req_write = 1'b1;
        bus.req_mem   = 1'b0;
        bus.req_addr  = 32'h0000_0080;
        bus.req_wdata = 8'h3C;
        @(negedge clk);
        bus.req_valid = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_mid/in_addr_oe", 32'(bus.lad_oe), 1);
        rst_n = 1'b0;
        #1;
        chk("rst_mid/lframe_n", 32'(bus.lframe_n), 1);
        chk("rst_mid/lad_out", 32'(bus.lad_out), 'hF);
        chk("rst_mid/lad_oe", 32'(bus.lad_oe), 0);
        chk("rst_mid/status", 32'(bus.rsp_status), 0);
        chk("rst_mid/rdata", 32'(bus.rsp_rdata), 0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk($sformatf("rst_mid/no_rsp%0d", i), 32'(bus.rsp_valid), 0);
        end
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("rst_mid/ready_after", 32'(bus.req_ready), 1);

        clr_lad();
        lad_seq[8] = 4'h0; lad_seq[9] = 4'h7; lad_seq[10] = 4'hE;
        run_txn("io_rd_post", 1'b0, 1'b0, 32'h0000_0071, 8'h00, 1'b0, 8'hE7, 2'b00, 13);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
